// File: rtl/alien_formation_ctrl_pkg.sv
// Shared invaders geometry, march timing constants and formation-controller types.
// The draw block imports the same geometry so the two agree on pitch and sprite size.
package alien_formation_ctrl_pkg;

  localparam int unsigned NUM_COLS    = 10;
  localparam int unsigned NUM_ROWS    = 5;
  localparam int unsigned NUM_ALIENS  = NUM_COLS * NUM_ROWS;
  localparam int unsigned ALIEN_W     = 30;
  localparam int unsigned ALIEN_H     = 20;
  localparam int unsigned PITCH_X     = 40;
  localparam int unsigned PITCH_Y     = 30;
  localparam int unsigned SCREEN_W    = 640;
  localparam int unsigned BOTTOM_ROW  = 440;

  localparam int unsigned START_COL   = 20;
  localparam int unsigned START_ROW   = 40;
  localparam int unsigned STEP_X      = 8;
  localparam int unsigned STEP_Y      = 10;
  localparam int unsigned MIN_PERIOD  = 2;
  localparam int unsigned SPEED_SHIFT = 2;

  localparam int unsigned COL_W   = 10;
  localparam int unsigned ROW_W   = 9;
  localparam int unsigned ARITH_W = 11;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned LIVE_W  = 6;
  localparam int unsigned CIDX_W  = 4;
  localparam int unsigned RIDX_W  = 3;

  localparam int unsigned RESET_PERIOD = MIN_PERIOD + (NUM_ALIENS >> SPEED_SHIFT);

  typedef enum logic [1:0] {
    MARCH_R = 2'd0,
    MARCH_L = 2'd1,
    HALT    = 2'd2
  } fsm_state_e;

  typedef struct packed {
    logic [CIDX_W-1:0] c_l;
    logic [CIDX_W-1:0] c_r;
    logic [RIDX_W-1:0] r_b;
    logic [LIVE_W-1:0] live;
    logic              any;
  } extent_t;

  // Fewer survivors -> shorter march period -> faster formation.
  function automatic logic [CNT_W-1:0] period_for(input logic [LIVE_W-1:0] live);
    return CNT_W'(MIN_PERIOD) + CNT_W'(live >> SPEED_SHIFT);
  endfunction

endpackage

// File: rtl/alien_formation_ctrl_if.sv
// Game-logic <-> formation controller signal bundle; master is the game side.
interface alien_formation_ctrl_if;
  import alien_formation_ctrl_pkg::*;

  logic                  FrameTick;
  logic                  Enable;
  logic                  Restart;
  logic [NUM_ALIENS-1:0] Aliens_Grid;
  logic [ROW_W-1:0]      AliensRow;
  logic [COL_W-1:0]      AliensCol;
  logic                  StepPulse;
  logic                  MovingLeft;
  logic                  Invaded;
  logic                  AllDead;

  modport master (
    output FrameTick, Enable, Restart, Aliens_Grid,
    input  AliensRow, AliensCol, StepPulse, MovingLeft, Invaded, AllDead
  );

  modport slave (
    input  FrameTick, Enable, Restart, Aliens_Grid,
    output AliensRow, AliensCol, StepPulse, MovingLeft, Invaded, AllDead
  );
endinterface

// File: rtl/alien_formation_ctrl_extent.sv
// Combinational live-alien extent: leftmost/rightmost live column, lowest live row, popcount.
module alien_formation_ctrl_extent
  import alien_formation_ctrl_pkg::*;
(
  input  logic [NUM_ALIENS-1:0] grid,
  output extent_t               ext
);

  logic [NUM_COLS-1:0] col_any;
  logic [NUM_ROWS-1:0] row_any;

  always_comb begin
    col_any = '0;
    row_any = '0;
    ext     = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if (grid[r*NUM_COLS + c]) begin
          col_any[c] = 1'b1;
          row_any[r] = 1'b1;
          ext.live   = ext.live + LIVE_W'(1);
        end
      end
    end
    // Descending scan leaves the lowest live column; ascending leaves the highest.
    for (int c = NUM_COLS - 1; c >= 0; c--) begin
      if (col_any[c]) ext.c_l = CIDX_W'(c);
    end
    for (int c = 0; c < NUM_COLS; c++) begin
      if (col_any[c]) ext.c_r = CIDX_W'(c);
    end
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (row_any[r]) ext.r_b = RIDX_W'(r);
    end
    ext.any = |grid;
  end

endmodule

// File: rtl/alien_formation_ctrl.sv
// Alien formation origin sequencer: frame-paced march, edge bounce with descent,
// survivor-based speed-up, and halt on invasion.
module alien_formation_ctrl
  import alien_formation_ctrl_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Reset,
  alien_formation_ctrl_if.slave bus
);

  extent_t ext;

  alien_formation_ctrl_extent u_extent (
    .grid (bus.Aliens_Grid),
    .ext  (ext)
  );

  fsm_state_e       state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             step_pulse_q, step_pulse_d;
  logic             moving_left_q, moving_left_d;
  logic             invaded_q, invaded_d;
  logic             all_dead_q, all_dead_d;

  logic [ARITH_W-1:0] desc_row;
  logic               right_ok, left_ok, hits_bottom, tick_ok;

  // Edge tests use the live extent so dead edge columns extend the travel.
  assign right_ok = (ARITH_W'(col_q) + ARITH_W'(ext.c_r) * ARITH_W'(PITCH_X)
                     + ARITH_W'(ALIEN_W + STEP_X)) <= ARITH_W'(SCREEN_W);
  assign left_ok  = (ARITH_W'(col_q) + ARITH_W'(ext.c_l) * ARITH_W'(PITCH_X))
                     >= ARITH_W'(STEP_X);
  assign desc_row    = ARITH_W'(row_q) + ARITH_W'(STEP_Y);
  assign hits_bottom = (desc_row + ARITH_W'(ext.r_b) * ARITH_W'(PITCH_Y)
                        + ARITH_W'(ALIEN_H)) >= ARITH_W'(BOTTOM_ROW);
  assign tick_ok  = bus.FrameTick & bus.Enable & (state_q != HALT) & ~all_dead_q;

  logic       descend;
  fsm_state_e turn_state;

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    frame_cnt_d   = frame_cnt_q;
    period_d      = period_q;
    step_pulse_d  = 1'b0;
    moving_left_d = moving_left_q;
    invaded_d     = invaded_q;
    all_dead_d    = ~ext.any;
    descend       = 1'b0;
    turn_state    = state_q;

    if (tick_ok) begin
      if (frame_cnt_q == period_q - CNT_W'(1)) begin
        frame_cnt_d  = '0;
        period_d     = period_for(ext.live);
        step_pulse_d = 1'b1;
        case (state_q)
          MARCH_R: begin
            if (right_ok) col_d = col_q + COL_W'(STEP_X);
            else begin
              descend    = 1'b1;
              turn_state = MARCH_L;
            end
          end
          MARCH_L: begin
            if (left_ok) col_d = col_q - COL_W'(STEP_X);
            else begin
              descend    = 1'b1;
              turn_state = MARCH_R;
            end
          end
          default: ;
        endcase
      end else begin
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end
    end

    // A descent that reaches the player line freezes the formation in place.
    if (descend) begin
      row_d = ROW_W'(desc_row);
      if (hits_bottom) begin
        state_d   = HALT;
        invaded_d = 1'b1;
      end else begin
        state_d       = turn_state;
        moving_left_d = (turn_state == MARCH_L);
      end
    end

    if (bus.Restart) begin
      state_d       = MARCH_R;
      col_d         = COL_W'(START_COL);
      row_d         = ROW_W'(START_ROW);
      frame_cnt_d   = '0;
      period_d      = CNT_W'(RESET_PERIOD);
      step_pulse_d  = 1'b0;
      moving_left_d = 1'b0;
      invaded_d     = 1'b0;
      all_dead_d    = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= MARCH_R;
      col_q         <= COL_W'(START_COL);
      row_q         <= ROW_W'(START_ROW);
      frame_cnt_q   <= '0;
      period_q      <= CNT_W'(RESET_PERIOD);
      step_pulse_q  <= 1'b0;
      moving_left_q <= 1'b0;
      invaded_q     <= 1'b0;
      all_dead_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      frame_cnt_q   <= frame_cnt_d;
      period_q      <= period_d;
      step_pulse_q  <= step_pulse_d;
      moving_left_q <= moving_left_d;
      invaded_q     <= invaded_d;
      all_dead_q    <= all_dead_d;
    end
  end

  assign bus.AliensRow  = row_q;
  assign bus.AliensCol  = col_q;
  assign bus.StepPulse  = step_pulse_q;
  assign bus.MovingLeft = moving_left_q;
  assign bus.Invaded    = invaded_q;
  assign bus.AllDead    = all_dead_q;

endmodule

// File: tb/tb_alien_formation_ctrl.sv
// Self-checking bench for alien_formation_ctrl: vector table plus step scoreboard.
module tb_alien_formation_ctrl;
  import alien_formation_ctrl_pkg::*;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  alien_formation_ctrl_if bus ();

  alien_formation_ctrl dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [9:0] col;
    logic [8:0] row;
    bit         left;
    bit         inv;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    bit          restart;
    logic [49:0] grid;
    bit          en;
    int          ticks;
    int          col;
    int          row;
    bit          left;
    bit          inv;
  } vec_t;
  vec_t vecs[14];

  // Reference model state
  int m_col, m_row, m_cnt, m_period;
  bit m_left, m_halt, m_inv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic extent(input logic [49:0] g, output int cl, output int cr,
                        output int rb, output int live);
    cl = 99; cr = -1; rb = -1; live = 0;
    for (int i = 0; i < 50; i++) begin
      if (g[i]) begin
        live++;
        if (i % 10 < cl) cl = i % 10;
        if (i % 10 > cr) cr = i % 10;
        if (i / 10 > rb) rb = i / 10;
      end
    end
  endtask

  task automatic model_reset();
    m_col = 20; m_row = 40; m_cnt = 0; m_period = 14;
    m_left = 0; m_halt = 0; m_inv = 0;
  endtask

  task automatic model_tick();
    int cl, cr, rb, live;
    bit desc;
    exp_t e;
    desc = 0;
    if (bus.Enable && !m_halt && bus.Aliens_Grid != 50'd0) begin
      if (m_cnt == m_period - 1) begin
        extent(bus.Aliens_Grid, cl, cr, rb, live);
        m_cnt    = 0;
        m_period = 2 + (live >> 2);
        if (!m_left) begin
          if (m_col + cr*40 + 30 + 8 <= 640) m_col += 8;
          else begin m_row += 10; m_left = 1; desc = 1; end
        end else begin
          if (m_col + cl*40 >= 8) m_col -= 8;
          else begin m_row += 10; m_left = 0; desc = 1; end
        end
        if (desc && (m_row + rb*30 + 20 >= 440)) begin
          m_inv = 1; m_halt = 1;
        end
        e.col = 10'(m_col); e.row = 9'(m_row); e.left = m_left; e.inv = m_inv;
        sb_q.push_back(e);
      end else begin
        m_cnt++;
      end
    end
  endtask

  // Called #1 after a posedge; returns #1 after a posedge.
  task automatic tick();
    model_tick();
    bus.FrameTick = 1'b1;
    @(posedge Clk); #1;
    bus.FrameTick = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic set_grid(input logic [49:0] g);
    bus.Aliens_Grid = g;
    @(posedge Clk); #1;
  endtask

  task automatic do_restart();
    bus.Restart = 1'b1;
    model_reset();
    @(posedge Clk); #1;
    bus.Restart = 1'b0;
  endtask

  // Scoreboard: every StepPulse must match the next queued model step.
  always @(posedge Clk) begin
    exp_t e;
    #1;
    if (Reset === 1'b0 && bus.StepPulse === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_step actual=StepPulse=1 required=no step at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        chk("step_col", 32'(bus.AliensCol), 32'(e.col));
        chk("step_row", 32'(bus.AliensRow), 32'(e.row));
        if (!e.inv) chk("step_left", 32'(bus.MovingLeft), 32'(e.left));
        chk("step_inv", 32'(bus.Invaded), 32'(e.inv));
      end
    end
  end

  logic [49:0] full_g, no89_g, pop8_g, inv_g;

  initial begin
    int n;
    int halt_col;

    full_g = '1;
    no89_g = '1;
    for (int r = 0; r < 5; r++) begin
      no89_g[r*10 + 8] = 1'b0;
      no89_g[r*10 + 9] = 1'b0;
    end
    pop8_g = 50'h00FF;
    inv_g  = '0;
    inv_g[40] = 1'b1;
    inv_g[49] = 1'b1;

    //          rst grid    en ticks  col  row left inv
    vecs[0]  = '{0, full_g, 1, 13,  20,  40, 0, 0};
    vecs[1]  = '{0, full_g, 1, 1,   28,  40, 0, 0};
    vecs[2]  = '{0, full_g, 1, 378, 244, 40, 0, 0};
    vecs[3]  = '{0, full_g, 1, 14,  244, 50, 1, 0};
    vecs[4]  = '{1, full_g, 1, 392, 244, 40, 0, 0};
    vecs[5]  = '{0, no89_g, 1, 122, 324, 40, 0, 0};
    vecs[6]  = '{0, no89_g, 1, 12,  324, 50, 1, 0};
    vecs[7]  = '{0, no89_g, 1, 5,   324, 50, 1, 0};
    vecs[8]  = '{0, no89_g, 0, 20,  324, 50, 1, 0};
    vecs[9]  = '{0, no89_g, 1, 6,   324, 50, 1, 0};
    vecs[10] = '{0, no89_g, 1, 1,   316, 50, 1, 0};
    vecs[11] = '{0, pop8_g, 1, 12,  308, 50, 1, 0};
    vecs[12] = '{0, pop8_g, 1, 3,   308, 50, 1, 0};
    vecs[13] = '{0, pop8_g, 1, 1,   300, 50, 1, 0};

    Reset = 1'b1;
    bus.FrameTick = 1'b0;
    bus.Enable = 1'b1;
    bus.Restart = 1'b0;
    bus.Aliens_Grid = full_g;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_col",   32'(bus.AliensCol),  32'd20);
    chk("rst_row",   32'(bus.AliensRow),  32'd40);
    chk("rst_left",  32'(bus.MovingLeft), 32'd0);
    chk("rst_inv",   32'(bus.Invaded),    32'd0);
    chk("rst_dead",  32'(bus.AllDead),    32'd0);
    chk("rst_pulse", 32'(bus.StepPulse),  32'd0);
    Reset = 1'b0;
    @(posedge Clk); #1;

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].restart) do_restart();
      set_grid(vecs[i].grid);
      bus.Enable = vecs[i].en;
      repeat (vecs[i].ticks) tick();
      chk($sformatf("vec%0d_col", i),  32'(bus.AliensCol),  32'(vecs[i].col));
      chk($sformatf("vec%0d_row", i),  32'(bus.AliensRow),  32'(vecs[i].row));
      chk($sformatf("vec%0d_left", i), 32'(bus.MovingLeft), 32'(vecs[i].left));
      chk($sformatf("vec%0d_inv", i),  32'(bus.Invaded),    32'(vecs[i].inv));
      chk($sformatf("vec%0d_dead", i), 32'(bus.AllDead),    32'd0);
    end
    bus.Enable = 1'b1;

    // March down to the player line; bottom row alive at both edge columns.
    do_restart();
    set_grid(inv_g);
    n = 0;
    while (bus.Invaded !== 1'b1 && n < 4000) begin
      tick();
      n++;
    end
    chk("invaded",       32'(bus.Invaded),   32'd1);
    chk("invaded_row",   32'(bus.AliensRow), 32'd300);
    chk("invaded_col",   32'(bus.AliensCol), 32'(m_col));
    halt_col = m_col;
    repeat (20) tick();
    chk("halt_col_held", 32'(bus.AliensCol), 32'(halt_col));
    chk("halt_row_held", 32'(bus.AliensRow), 32'd300);
    do_restart();
    chk("restart_col",  32'(bus.AliensCol),  32'd20);
    chk("restart_row",  32'(bus.AliensRow),  32'd40);
    chk("restart_inv",  32'(bus.Invaded),    32'd0);
    chk("restart_left", 32'(bus.MovingLeft), 32'd0);

    // All dead: no steps; then async reset mid-cycle.
    set_grid(full_g);
    repeat (14) tick();
    chk("pre_dead_col", 32'(bus.AliensCol), 32'd28);
    set_grid(50'd0);
    chk("all_dead", 32'(bus.AllDead), 32'd1);
    repeat (30) tick();
    chk("dead_col_held", 32'(bus.AliensCol), 32'd28);
    chk("dead_row_held", 32'(bus.AliensRow), 32'd40);
    #2;
    Reset = 1'b1;
    #1;
    chk("async_rst_col",  32'(bus.AliensCol), 32'd20);
    chk("async_rst_dead", 32'(bus.AllDead),   32'd0);
    chk("async_rst_row",  32'(bus.AliensRow), 32'd40);
    sb_q.delete();
    model_reset();
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(posedge Clk); #1;

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
